divider_nbit_seq: RTL and testbench

Sequential restoring divider, the inverse arithmetic companion of the team's combinational n-bit adder.
- Accepts a dividend/divisor pair on a start strobe.
- Produces one quotient bit per cycle using a shift-subtract-restore loop, then reports quotient, remainder and status.
- Sits beside the adder in the datapath library; the divide ALU op and the lab checker bench use it.

---
 rtl/divider_pkg.sv | 23 ++
 rtl/div_iter_counter.sv | 33 +++
 rtl/divider_nbit_seq.sv | 169 ++++++++++++++++
 tb/tb_divider_nbit_seq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
`default_nettype none
// ============================================================================
// Module : divider_pkg
// Brief  : Shared state encoding and sizing helper for the sequential divider.
// Rev    : 1.0  initial release
// ============================================================================
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    DONE   = 2'd2
  } div_state_t;

  localparam int DEFAULT_NUM_BITS = 4;

  // Iteration counter must reach NUM_BITS itself, hence the +1.
  function automatic int cnt_width(input int num_bits);
    return $clog2(num_bits + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/div_iter_counter.sv
`default_nettype none
// ============================================================================
// Module : div_iter_counter
// Brief  : Iteration counter with clear, enable and a rollover flag at ROLLOVER_VAL.
// Rev    : 1.0  initial release
// ============================================================================
module div_iter_counter #(
  parameter int CNT_W        = 3,
  parameter int ROLLOVER_VAL = 4
) (
  input  logic clk,
  input  logic n_rst,
  input  logic i_clear,
  input  logic i_count_enable,
  output logic o_rollover_flag
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_count_enable) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_rollover_flag = (r_count == CNT_W'(ROLLOVER_VAL));

endmodule
`default_nettype wire

// File: rtl/divider_nbit_seq.sv
`default_nettype none
// ============================================================================
// Module : divider_nbit_seq
// Brief  : Sequential restoring divider, one quotient bit per cycle.
//          Define DIVIDER_SIGNED_EN for two's-complement operands.
// Rev    : 1.0  initial release
// ============================================================================
module divider_nbit_seq
  import divider_pkg::*;
#(
  parameter int NUM_BITS = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic [NUM_BITS-1:0] dividend,
  input  logic [NUM_BITS-1:0] divisor,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] quotient,
  output logic [NUM_BITS-1:0] remainder,
  output logic                div_by_zero
);

  localparam int CNT_W = cnt_width(NUM_BITS);

  div_state_t          r_state;
  div_state_t          w_next_state;
  logic [NUM_BITS-1:0] r_quo;
  logic [NUM_BITS-1:0] r_rem;
  logic [NUM_BITS-1:0] r_divisor;
  logic [NUM_BITS-1:0] r_dividend;
  logic                r_dbz;
  logic                w_accept;
  logic                w_finish;
  logic                w_iter;
  logic                w_rollover;
  logic [NUM_BITS-1:0] w_dvd_mag;
  logic [NUM_BITS-1:0] w_dvs_mag;
  logic [NUM_BITS-1:0] w_quo_out;
  logic [NUM_BITS-1:0] w_rem_out;
  logic [NUM_BITS:0]   w_part;
  logic [NUM_BITS:0]   w_trial;
  logic                w_nonneg;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // A zero divisor still spends one DIVIDE cycle so busy is seen for a cycle.
  always_comb begin
    w_next_state = r_state;
    w_finish     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = DIVIDE;
        end
      end
      DIVIDE: begin
        if (r_dbz || w_rollover) begin
          w_next_state = DONE;
          w_finish     = 1'b1;
        end
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  assign w_accept = (r_state == IDLE) && start;
  assign w_iter   = (r_state == DIVIDE) && !w_finish;
  assign busy     = (r_state == DIVIDE);
  assign done     = (r_state == DONE);

  div_iter_counter #(
    .CNT_W        (CNT_W),
    .ROLLOVER_VAL (NUM_BITS)
  ) u_iter_counter (
    .clk             (clk),
    .n_rst           (n_rst),
    .i_clear         (w_accept),
    .i_count_enable  (w_iter),
    .o_rollover_flag (w_rollover)
  );

  // Shifted partial remainder can exceed NUM_BITS; if its top bit is set it
  // is certainly >= divisor, otherwise the trial borrow decides.
  assign w_part   = {r_rem, r_quo[NUM_BITS-1]};
  assign w_trial  = w_part - {1'b0, r_divisor};
  assign w_nonneg = w_part[NUM_BITS] | ~w_trial[NUM_BITS];

`ifdef DIVIDER_SIGNED_EN
  logic r_q_neg;
  logic r_r_neg;

  assign w_dvd_mag = dividend[NUM_BITS-1] ? (~dividend + NUM_BITS'(1)) : dividend;
  assign w_dvs_mag = divisor[NUM_BITS-1]  ? (~divisor  + NUM_BITS'(1)) : divisor;
  assign w_quo_out = r_q_neg ? (~r_quo + NUM_BITS'(1)) : r_quo;
  assign w_rem_out = r_r_neg ? (~r_rem + NUM_BITS'(1)) : r_rem;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
    end else if (w_accept) begin
      r_q_neg <= dividend[NUM_BITS-1] ^ divisor[NUM_BITS-1];
      r_r_neg <= dividend[NUM_BITS-1];
    end
  end
`else
  assign w_dvd_mag = dividend;
  assign w_dvs_mag = divisor;
  assign w_quo_out = r_quo;
  assign w_rem_out = r_rem;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_quo      <= '0;
      r_rem      <= '0;
      r_divisor  <= '0;
      r_dividend <= '0;
      r_dbz      <= 1'b0;
    end else if (w_accept) begin
      r_quo      <= w_dvd_mag;
      r_rem      <= '0;
      r_divisor  <= w_dvs_mag;
      r_dividend <= dividend;
      r_dbz      <= (divisor == '0);
    end else if (w_iter) begin
      if (w_nonneg) begin
        r_rem <= w_trial[NUM_BITS-1:0];
        r_quo <= {r_quo[NUM_BITS-2:0], 1'b1};
      end else begin
        r_rem <= w_part[NUM_BITS-1:0];
        r_quo <= {r_quo[NUM_BITS-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (w_finish) begin
      if (r_dbz) begin
        quotient    <= '1;
        remainder   <= r_dividend;
        div_by_zero <= 1'b1;
      end else begin
        quotient    <= w_quo_out;
        remainder   <= w_rem_out;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_divider_nbit_seq.sv
`default_nettype none
// Testbench for divider_nbit_seq: cycle-level behavioural model plus
// directed literal cases, random traffic and a full operand sweep.
module tb_divider_nbit_seq;

  localparam int NB   = 4;
  localparam int MASK = (1 << NB) - 1;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          start = 1'b0;
  logic [NB-1:0] dividend = '0;
  logic [NB-1:0] divisor = '0;
  logic          busy;
  logic          done;
  logic [NB-1:0] quotient;
  logic [NB-1:0] remainder;
  logic          div_by_zero;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  divider_nbit_seq #(.NUM_BITS(NB)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the operation's definition.
  function automatic void ref_div(input int a, input int b,
                                  output int q, output int r, output int z);
    int sa, sb;
    if (b == 0) begin
      q = MASK; r = a; z = 1;
    end else begin
`ifdef DIVIDER_SIGNED_EN
      sa = (a >= (1 << (NB-1))) ? a - (1 << NB) : a;
      sb = (b >= (1 << (NB-1))) ? b - (1 << NB) : b;
      q = (sa / sb) & MASK;
      r = (sa % sb) & MASK;
`else
      sa = a; sb = b;
      q = sa / sb;
      r = sa % sb;
`endif
      z = 0;
    end
  endfunction

  // Model: cycles of busy remaining, a done flag, and the held results.
  int m_left = 0;
  bit m_done = 1'b0;
  int m_q = 0, m_r = 0, m_z = 0;
  int p_q = 0, p_r = 0, p_z = 0;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_left = 0; m_done = 1'b0; m_q = 0; m_r = 0; m_z = 0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_done = 1'b1; m_q = p_q; m_r = p_r; m_z = p_z;
      end
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (start) begin
      ref_div(int'(dividend), int'(divisor), p_q, p_r, p_z);
      m_left = (divisor == '0) ? 1 : NB + 1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", int'(busy), int'(m_left > 0));
      chk("done", int'(done), int'(m_done));
      chk("quotient", int'(quotient), m_q);
      chk("remainder", int'(remainder), m_r);
      chk("div_by_zero", int'(div_by_zero), m_z);
      if (done) done_cnt++;
    end
  end

  task automatic start_op(input int a, input int b);
    dividend = NB'(a);
    divisor  = NB'(b);
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 3*NB + 10) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", int'(done), 1);
  endtask

  task automatic run_lit(input int a, input int b, input int eq, input int er, input int ez);
    start_op(a, b);
    wait_done();
    chk("lit_quotient", int'(quotient), eq);
    chk("lit_remainder", int'(remainder), er);
    chk("lit_div_by_zero", int'(div_by_zero), ez);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bc, dc;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_quotient", int'(quotient), 0);
    chk("reset_remainder", int'(remainder), 0);
    chk("reset_div_by_zero", int'(div_by_zero), 0);

`ifndef DIVIDER_SIGNED_EN
    start_op(13, 3);
    bc = 0;
    while (busy && bc < 20) begin
      bc++;
      @(negedge clk);
    end
    chk("busy_cycles", bc, NB + 1);
    chk("done_13_3", int'(done), 1);
    chk("lit_q_13_3", int'(quotient), 4);
    chk("lit_r_13_3", int'(remainder), 1);
    @(negedge clk);
    chk("done_pulse_len", int'(done), 0);
    repeat (10) @(negedge clk);
    chk("held_q", int'(quotient), 4);
    chk("held_r", int'(remainder), 1);

    start_op(7, 0);
    chk("dbz_not_done_yet", int'(done), 0);
    @(negedge clk);
    chk("dbz_done_latency", int'(done), 1);
    chk("lit_q_7_0", int'(quotient), 15);
    chk("lit_r_7_0", int'(remainder), 7);
    chk("lit_z_7_0", int'(div_by_zero), 1);
    @(negedge clk);
    run_lit(15, 1, 15, 0, 0);

    dc = done_cnt;
    start_op(9, 2);
    @(negedge clk);
    start_op(14, 7);
    wait_done();
    chk("ignored_start_q", int'(quotient), 4);
    chk("ignored_start_r", int'(remainder), 1);
    repeat (5) @(negedge clk);
    chk("single_done", done_cnt - dc, 1);

    start_op(15, 4);
    @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_quotient", int'(quotient), 0);
    chk("abort_remainder", int'(remainder), 0);
    dc = done_cnt;
    repeat (4) @(negedge clk);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_no_done", done_cnt - dc, 0);
    run_lit(15, 4, 3, 3, 0);
`else
    run_lit(9, 2, 13, 15, 0);
    run_lit(8, 15, 8, 0, 0);
    run_lit(7, 0, 15, 7, 1);
    run_lit(6, 13, 14, 0, 0);
`endif

    for (int i = 0; i < 300; i++) begin
      start    = (i >= 100 && i < 140) ? 1'b1 : ($urandom_range(0, 3) == 0);
      dividend = NB'($urandom_range(0, MASK));
      divisor  = NB'($urandom_range(0, MASK));
      @(negedge clk);
    end
    start = 1'b0;
    repeat (NB + 4) @(negedge clk);

    for (int a = 0; a <= MASK; a++) begin
      for (int b = 0; b <= MASK; b++) begin
        start_op(a, b);
        wait_done();
        @(negedge clk);
      end
    end

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
